// File: rtl/sys_arr_pkg.sv
// Shared types for the systolic-array adder driver.
//   add_drv_state_t : driver FSM states
//   add_op_t        : one queued operation {a, b, tag}
//   ADD_LATENCY     : cycles from adder start to value_ready
package sys_arr_pkg;

   localparam int SYS_DATA_W  = 16;
   localparam int SYS_TAG_W   = 4;
   localparam int ADD_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } add_drv_state_t;

   // Field widths follow SYS_DATA_W/SYS_TAG_W; the driver's DATA_W/TAG_W
   // parameters must be left at these values.
   typedef struct packed {
      logic [SYS_DATA_W-1:0] a;
      logic [SYS_DATA_W-1:0] b;
      logic [SYS_TAG_W-1:0]  tag;
   } add_op_t;

endpackage

// File: rtl/sysarr_add_fifo.sv
// Operand FIFO for the adder driver.
//   clk, rst      : clock, async active-high reset
//   push_i/data_i : write one add_op_t (caller guarantees not full)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   head_o        : current head entry (valid when !empty_o)
//   count_o       : occupancy, full_o / empty_o derived from it
module sysarr_add_fifo
   import sys_arr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  add_op_t                  data_i,
   input  logic                     pop_i,
   output add_op_t                  head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   add_op_t            mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W:0]     count_q;

   // Storage needs no reset; count_q alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/sysarr_add_driver.sv
// Initiator for the systolic-array adder (adder modport). Queues operand
// pairs, runs one add at a time, holds operands until value_ready and
// returns tagged sums on a valid/ready stream. A watchdog flags an adder
// that never answers; add_ready outside WAIT is also flagged.
// The adder's nRST is tied to ~RST by the enclosing level.
//   op_*      : operand stream in (op_ready = FIFO not full)
//   add_*     : adder interface (start, operands, value_ready, output)
//   res_*     : result stream out
//   busy      : FSM active or operations queued
//   err/err_clr : sticky protocol error and its clear
//
// state | meaning
// IDLE  | nothing in flight; pop the FIFO head if present
// ISSUE | add_start high for this one cycle
// WAIT  | operands held, waiting for add_ready, watchdog counting
// RESP  | res_valid high until res_ready
module sysarr_add_driver
   import sys_arr_pkg::*;
#(
   parameter int DATA_W     = SYS_DATA_W,
   parameter int TAG_W      = SYS_TAG_W,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [TAG_W-1:0]  op_tag,
   output logic              add_start,
   output logic [DATA_W-1:0] add_in1,
   output logic [DATA_W-1:0] add_in2,
   input  logic              add_ready,
   input  logic [DATA_W-1:0] add_sum,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_sum,
   output logic [TAG_W-1:0]  res_tag,
   output logic              busy,
   output logic              err,
   input  logic              err_clr
);

   localparam int TMR_W = $clog2(TIMEOUT);

   add_drv_state_t            state_q;
   logic [DATA_W-1:0]         add_in1_q, add_in2_q;
   logic [TAG_W-1:0]          tag_q;
   logic [DATA_W-1:0]         res_sum_q;
   logic [TAG_W-1:0]          res_tag_q;
   logic                      res_valid_q;
   logic                      add_start_q;
   logic [TMR_W-1:0]          timer_q;
   logic                      err_q, err_d;

   add_op_t                   fifo_in, fifo_head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                      fifo_full, fifo_empty;
   logic                      fifo_push, fifo_pop;
   logic                      spurious, timeout_hit;

   assign fifo_in   = '{a: op_a, b: op_b, tag: op_tag};
   assign fifo_push = op_valid & ~fifo_full;
   // Pop in IDLE, or in RESP on the handshake so the next op issues back-to-back.
   assign fifo_pop  = ~fifo_empty &
                      ((state_q == IDLE) | ((state_q == RESP) & res_ready));

   sysarr_add_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (RST),
      .push_i  (fifo_push),
      .data_i  (fifo_in),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign spurious    = add_ready & (state_q != WAIT);
   assign timeout_hit = (state_q == WAIT) & ~add_ready &
                        (timer_q == TMR_W'(TIMEOUT-1));
   // An error event wins over a same-cycle clear.
   assign err_d = (err_q & ~err_clr) | spurious | timeout_hit;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         add_in1_q   <= '0;
         add_in2_q   <= '0;
         tag_q       <= '0;
         res_sum_q   <= '0;
         res_tag_q   <= '0;
         res_valid_q <= 1'b0;
         add_start_q <= 1'b0;
         timer_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q       <= err_d;
         add_start_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (fifo_pop) begin
                  add_in1_q   <= fifo_head.a;
                  add_in2_q   <= fifo_head.b;
                  tag_q       <= fifo_head.tag;
                  add_start_q <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               timer_q <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (add_ready) begin
                  res_sum_q   <= add_sum;
                  res_tag_q   <= tag_q;
                  res_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else if (timeout_hit) begin
                  // Adder never answered: drop the op.
                  add_in1_q <= '0;
                  add_in2_q <= '0;
                  timer_q   <= '0;
                  state_q   <= IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  if (fifo_pop) begin
                     add_in1_q   <= fifo_head.a;
                     add_in2_q   <= fifo_head.b;
                     tag_q       <= fifo_head.tag;
                     add_start_q <= 1'b1;
                     state_q     <= ISSUE;
                  end else begin
                     add_in1_q <= '0;
                     add_in2_q <= '0;
                     state_q   <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign op_ready  = ~fifo_full;
   assign add_start = add_start_q;
   assign add_in1   = add_in1_q;
   assign add_in2   = add_in2_q;
   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_tag   = res_tag_q;
   assign busy      = (state_q != IDLE) | ~fifo_empty;
   assign err       = err_q;

endmodule

// File: tb/tb_sysarr_add_driver.sv
// Directed bench for sysarr_add_driver with a 2-cycle adder stub.
module tb_sysarr_add_driver;

   localparam int DATA_W = 16;
   localparam int TAG_W  = 4;

   logic              clk = 1'b0;
   logic              RST;
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a, op_b;
   logic [TAG_W-1:0]  op_tag;
   logic              add_start;
   logic [DATA_W-1:0] add_in1, add_in2;
   logic              add_ready;
   logic [DATA_W-1:0] add_sum;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_sum;
   logic [TAG_W-1:0]  res_tag;
   logic              busy;
   logic              err;
   logic              err_clr;

   always #5 clk = ~clk;

   sysarr_add_driver #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .FIFO_DEPTH(4), .TIMEOUT(8)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_tag    (op_tag),
      .add_start (add_start),
      .add_in1   (add_in1),
      .add_in2   (add_in2),
      .add_ready (add_ready),
      .add_sum   (add_sum),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_tag   (res_tag),
      .busy      (busy),
      .err       (err),
      .err_clr   (err_clr)
   );

   // Adder stub: value_ready two cycles after start; reset with RST (nRST = ~RST).
   logic              adder_en = 1'b1;
   logic              spur = 1'b0;
   logic              s1, s2;
   logic [DATA_W-1:0] p1, p2;

   always @(posedge clk or posedge RST) begin
      if (RST) begin
         s1 <= 1'b0; s2 <= 1'b0; p1 <= '0; p2 <= '0;
      end else begin
         s1 <= add_start;
         p1 <= add_in1 + add_in2;
         s2 <= s1;
         p2 <= p1;
      end
   end

   assign add_ready = (s2 & adder_en) | spur;
   assign add_sum   = p2;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_result(input logic [DATA_W-1:0] es, input logic [TAG_W-1:0] et,
                              input string nm);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (res_valid) begin
            chk({nm, "_sum"}, res_sum, es);
            chk({nm, "_tag"}, res_tag, et);
            got = 1'b1;
            step();
            break;
         end
         step();
      end
      chk({nm, "_seen"}, got, 1);
   endtask

   // Operands must not move between add_start and add_ready.
   logic              stab_en = 1'b1;
   logic              lat_vld = 1'b0;
   logic [DATA_W-1:0] lat1, lat2;

   always begin
      @(posedge clk);
      #1;
      if (add_start) begin
         lat1    = add_in1;
         lat2    = add_in2;
         lat_vld = 1'b1;
      end else if (add_ready && stab_en && lat_vld) begin
         chk("hold_in1", add_in1, lat1);
         chk("hold_in2", add_in2, lat2);
         lat_vld = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      bit any_valid;
      RST = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; op_tag = '0;
      res_ready = 1'b1; err_clr = 1'b0;
      step(); step();
      chk("rst_op_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_start", add_start, 0);
      chk("rst_in1", add_in1, 0);
      chk("rst_err", err, 0);
      RST = 1'b0;
      step();

      // Single op: cycle 0 push, start at 2, result at 5.
      op_valid = 1'b1; op_a = 16'h0003; op_b = 16'h0005; op_tag = 4'd2;
      step();
      op_valid = 1'b0;
      chk("s_c1_start", add_start, 0);
      step();
      chk("s_c2_start", add_start, 1);
      chk("s_c2_in1", add_in1, 16'h0003);
      chk("s_c2_in2", add_in2, 16'h0005);
      step();
      chk("s_c3_start", add_start, 0);
      chk("s_c3_valid", res_valid, 0);
      step();
      chk("s_c4_valid", res_valid, 0);
      step();
      chk("s_c5_valid", res_valid, 1);
      chk("s_c5_sum", res_sum, 16'h0008);
      chk("s_c5_tag", res_tag, 2);
      step();
      chk("s_c6_valid", res_valid, 0);
      chk("s_c6_busy", busy, 0);
      chk("s_c6_in1", add_in1, 0);

      // Overflow wraps in the adder.
      op_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'h0002; op_tag = 4'd7;
      step();
      op_valid = 1'b0;
      wait_result(16'h0001, 4'd7, "ovf");
      step(); step();

      // Stalled result while four more ops fill the FIFO.
      res_ready = 1'b0;
      op_valid = 1'b1; op_a = 16'h0010; op_b = 16'h0020; op_tag = 4'd5;
      step();
      for (int k = 1; k <= 4; k++) begin
         op_a = 16'(k); op_b = 16'(k); op_tag = 4'(k - 1);
         if (k == 4) chk("burst_ready_c4", op_ready, 1);
         step();
      end
      op_valid = 1'b0;
      chk("burst_full", op_ready, 0);
      for (int k = 0; k < 10; k++) begin
         chk("stall_valid", res_valid, 1);
         chk("stall_sum", res_sum, 16'h0030);
         chk("stall_tag", res_tag, 5);
         chk("stall_start", add_start, 0);
         step();
      end
      res_ready = 1'b1;
      wait_result(16'h0030, 4'd5, "stall");
      wait_result(16'h0002, 4'd0, "b0");
      wait_result(16'h0004, 4'd1, "b1");
      wait_result(16'h0006, 4'd2, "b2");
      wait_result(16'h0008, 4'd3, "b3");
      step();
      chk("burst_idle_busy", busy, 0);
      chk("burst_ready_back", op_ready, 1);

      // Watchdog: adder never answers.
      stab_en = 1'b0; adder_en = 1'b0;
      op_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0001; op_tag = 4'd1;
      step();
      op_valid = 1'b0;
      step();
      chk("to_c2_start", add_start, 1);
      repeat (8) step();
      chk("to_c10_err", err, 0);
      step();
      chk("to_c11_err", err, 1);
      chk("to_c11_busy", busy, 0);
      chk("to_c11_in1", add_in1, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("to_clr", err, 0);

      // Spurious add_ready in IDLE, and clear colliding with an event.
      spur = 1'b1;
      step();
      spur = 1'b0;
      chk("spur_err", err, 1);
      spur = 1'b1; err_clr = 1'b1;
      step();
      spur = 1'b0; err_clr = 1'b0;
      chk("clr_vs_evt", err, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("spur_clr", err, 0);
      adder_en = 1'b1; stab_en = 1'b1;
      step();

      // Reset in WAIT with two ops queued.
      op_valid = 1'b1; op_a = 16'h000A; op_b = 16'h0001; op_tag = 4'd8;
      step();
      op_b = 16'h0002;
      step();
      op_b = 16'h0003;
      step();
      op_valid = 1'b0;
      chk("mr_busy_pre", busy, 1);
      RST = 1'b1;
      #1;
      chk("mr_op_ready", op_ready, 1);
      chk("mr_busy", busy, 0);
      chk("mr_start", add_start, 0);
      chk("mr_in1", add_in1, 0);
      chk("mr_in2", add_in2, 0);
      chk("mr_valid", res_valid, 0);
      chk("mr_sum", res_sum, 0);
      chk("mr_tag", res_tag, 0);
      chk("mr_err", err, 0);
      step();
      RST = 1'b0;
      any_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (res_valid) any_valid = 1'b1;
         step();
      end
      chk("mr_no_result", any_valid, 0);
      chk("mr_idle_busy", busy, 0);
      op_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1111; op_tag = 4'd9;
      step();
      op_valid = 1'b0;
      wait_result(16'h2345, 4'd9, "mr_next");
      chk("mr_err_end", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
